// File: rtl/fp16_add_align_if.sv
// Valid/ready operand and result bundle for the FP16 adder front half.
// slave = the adder stage, master = whoever feeds and drains it.
interface fp16_add_align_if #(
  parameter int MB = 11,
  parameter int EB = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EB:0]   out_exp;
  logic [MB:0]   out_mant;
  logic [2:0]    out_grs;
  logic          out_nan;
  logic          out_inf;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_grs, out_nan, out_inf
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_grs, out_nan, out_inf
  );
endinterface

// File: rtl/fp16_add_align.sv
// FP16 adder front half: unpack/swap (S1), align and add/subtract (S2).
// Emits an unnormalized sum with guard/round/sticky for the normalize stage.
module fp16_add_align (
  input  logic               clk_i,
  input  logic               rst_i,
  fp16_add_align_if.slave    bus
);

  logic s1_en, s2_en;
  logic s1_valid_q, s2_valid_q;

  assign s2_en        = !s2_valid_q || bus.out_ready;
  assign s1_en        = !s1_valid_q || s2_en;
  assign bus.in_ready = s1_en;

  // ---------------- S1: unpack and order by magnitude ----------------
  logic [4:0]  exp_a, exp_b, eexp_a, eexp_b;
  logic [9:0]  frac_a, frac_b;
  logic [10:0] sig_a, sig_b;
  logic        sign_a, sign_b;
  logic        nan_a, nan_b, inf_a, inf_b, a_is_l;

  assign exp_a  = bus.in_a[14:10];
  assign exp_b  = bus.in_b[14:10];
  assign frac_a = bus.in_a[9:0];
  assign frac_b = bus.in_b[9:0];
  assign sign_a = bus.in_a[15];
  assign sign_b = bus.in_b[15] ^ bus.in_sub;
  assign sig_a  = {|exp_a, frac_a};
  assign sig_b  = {|exp_b, frac_b};
  assign eexp_a = (exp_a == 5'd0) ? 5'd1 : exp_a;
  assign eexp_b = (exp_b == 5'd0) ? 5'd1 : exp_b;
  assign nan_a  = (&exp_a) &&  (|frac_a);
  assign nan_b  = (&exp_b) &&  (|frac_b);
  assign inf_a  = (&exp_a) && !(|frac_a);
  assign inf_b  = (&exp_b) && !(|frac_b);
  assign a_is_l = bus.in_a[14:0] >= bus.in_b[14:0];

  logic [10:0] s1_sig_l_q, s1_sig_l_d, s1_sig_s_q, s1_sig_s_d;
  logic [4:0]  s1_exp_l_q, s1_exp_l_d, s1_d_q, s1_d_d;
  logic        s1_sign_l_q, s1_sign_l_d, s1_sign_s_q, s1_sign_s_d;
  logic        s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d, s1_inf_sign_q, s1_inf_sign_d;

  always_comb begin
    if (a_is_l) begin
      s1_sig_l_d  = sig_a;
      s1_sig_s_d  = sig_b;
      s1_exp_l_d  = eexp_a;
      s1_d_d      = eexp_a - eexp_b;
      s1_sign_l_d = sign_a;
      s1_sign_s_d = sign_b;
    end else begin
      s1_sig_l_d  = sig_b;
      s1_sig_s_d  = sig_a;
      s1_exp_l_d  = eexp_b;
      s1_d_d      = eexp_b - eexp_a;
      s1_sign_l_d = sign_b;
      s1_sign_s_d = sign_a;
    end
    // Inf - Inf of opposite effective sign is invalid
    s1_nan_d      = nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b));
    s1_inf_d      = !s1_nan_d && (inf_a || inf_b);
    s1_inf_sign_d = inf_a ? sign_a : sign_b;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q    <= 1'b0;
      s1_sig_l_q    <= '0;
      s1_sig_s_q    <= '0;
      s1_exp_l_q    <= '0;
      s1_d_q        <= '0;
      s1_sign_l_q   <= 1'b0;
      s1_sign_s_q   <= 1'b0;
      s1_nan_q      <= 1'b0;
      s1_inf_q      <= 1'b0;
      s1_inf_sign_q <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sig_l_q    <= s1_sig_l_d;
        s1_sig_s_q    <= s1_sig_s_d;
        s1_exp_l_q    <= s1_exp_l_d;
        s1_d_q        <= s1_d_d;
        s1_sign_l_q   <= s1_sign_l_d;
        s1_sign_s_q   <= s1_sign_s_d;
        s1_nan_q      <= s1_nan_d;
        s1_inf_q      <= s1_inf_d;
        s1_inf_sign_q <= s1_inf_sign_d;
      end
    end
  end

  // ---------------- S2: align, combine, resolve specials ----------------
  logic [13:0] l_ext, s_full, s_shift, s_mask, s_ext;
  logic [14:0] res;
  logic        eff_sub;

  assign l_ext   = {s1_sig_l_q, 3'b000};
  assign s_full  = {s1_sig_s_q, 3'b000};
  assign eff_sub = s1_sign_l_q != s1_sign_s_q;

  always_comb begin
    s_shift = s_full >> s1_d_q;
    s_mask  = (14'd1 << s1_d_q) - 14'd1;
    if (s1_d_q >= 5'd14) s_ext = {13'd0, |s1_sig_s_q};
    else                 s_ext = s_shift | {13'd0, |(s_full & s_mask)};
    res = eff_sub ? ({1'b0, l_ext} - {1'b0, s_ext}) : ({1'b0, l_ext} + {1'b0, s_ext});
  end

  logic        out_sign_q, out_sign_d, out_nan_q, out_nan_d, out_inf_q, out_inf_d;
  logic [5:0]  out_exp_q, out_exp_d;
  logic [11:0] out_mant_q, out_mant_d;
  logic [2:0]  out_grs_q, out_grs_d;

  always_comb begin
    out_nan_d  = s1_nan_q;
    out_inf_d  = s1_inf_q;
    out_sign_d = 1'b0;
    out_exp_d  = '0;
    out_mant_d = '0;
    out_grs_d  = '0;
    if (s1_inf_q) begin
      out_sign_d = s1_inf_sign_q;
    end else if (!s1_nan_q) begin
      out_mant_d = res[14:3];
      out_grs_d  = res[2:0];
      out_exp_d  = {1'b0, s1_exp_l_q};
      // exact cancellation yields +0
      out_sign_d = (eff_sub && (res == 15'd0)) ? 1'b0 : s1_sign_l_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      out_sign_q <= 1'b0;
      out_nan_q  <= 1'b0;
      out_inf_q  <= 1'b0;
      out_exp_q  <= '0;
      out_mant_q <= '0;
      out_grs_q  <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_q <= out_sign_d;
        out_nan_q  <= out_nan_d;
        out_inf_q  <= out_inf_d;
        out_exp_q  <= out_exp_d;
        out_mant_q <= out_mant_d;
        out_grs_q  <= out_grs_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_grs   = out_grs_q;
  assign bus.out_nan   = out_nan_q;
  assign bus.out_inf   = out_inf_q;

endmodule

// File: tb/tb_fp16_add_align.sv
// Bench for fp16_add_align: directed vector table, backpressure/reset
// sequences and randomized traffic against an integer reference model.
module tb_fp16_add_align;

  typedef struct packed {
    logic        sign;
    logic [5:0]  exp;
    logic [11:0] mant;
    logic [2:0]  grs;
    logic        nan;
    logic        inf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    res_t        r;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_add_align_if bus ();

  fp16_add_align dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   out_cnt = 0;
  res_t sb_q[$];

  function automatic res_t mk(logic s, int e, int m, int g, logic n, logic i);
    res_t r;
    r.sign = s;
    r.exp  = 6'(e);
    r.mant = 12'(m);
    r.grs  = 3'(g);
    r.nan  = n;
    r.inf  = i;
    return r;
  endfunction

  // Reference: plain integer arithmetic; alignment via divide/remainder by 2**d.
  function automatic res_t ref_model(logic [15:0] a, logic [15:0] b, logic sub);
    res_t   r;
    longint ea, eb, fa, fb, siga, sigb, eea, eeb, sigl, sigs, eel, ees, d, p, ls, ss, sal, rs;
    logic   sa, sb, sl, ss_sign, na, nb, ia, ib, same;
    r  = '0;
    ea = longint'(a[14:10]);  fa = longint'(a[9:0]);
    eb = longint'(b[14:10]);  fb = longint'(b[9:0]);
    sa = a[15];
    sb = b[15] ^ sub;
    na = (ea == 31) && (fa != 0);  ia = (ea == 31) && (fa == 0);
    nb = (eb == 31) && (fb != 0);  ib = (eb == 31) && (fb == 0);
    if (na || nb || (ia && ib && sa != sb)) begin
      r.nan = 1'b1;
      return r;
    end
    if (ia || ib) begin
      r.inf  = 1'b1;
      r.sign = ia ? sa : sb;
      return r;
    end
    siga = (ea == 0) ? fa : fa + 1024;  eea = (ea == 0) ? 1 : ea;
    sigb = (eb == 0) ? fb : fb + 1024;  eeb = (eb == 0) ? 1 : eb;
    if (ea * 1024 + fa >= eb * 1024 + fb) begin
      sigl = siga; eel = eea; sl = sa; sigs = sigb; ees = eeb; ss_sign = sb;
    end else begin
      sigl = sigb; eel = eeb; sl = sb; sigs = siga; ees = eea; ss_sign = sa;
    end
    d   = eel - ees;
    p   = longint'(1) << d;
    ls  = sigl * 8;
    ss  = sigs * 8;
    sal = ss / p;
    if (ss % p != 0) sal = sal | 1;
    same = (sl == ss_sign);
    rs   = same ? ls + sal : ls - sal;
    r.mant = rs[14:3];
    r.grs  = rs[2:0];
    r.exp  = eel[5:0];
    r.sign = (!same && rs == 0) ? 1'b0 : sl;
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.sign = bus.out_sign;
    r.exp  = bus.out_exp;
    r.mant = bus.out_mant;
    r.grs  = bus.out_grs;
    r.nan  = bus.out_nan;
    r.inf  = bus.out_inf;
    return r;
  endfunction

  // NaN sign is not defined, so it is left out of the comparison.
  task automatic check_res(string name, res_t got, res_t exp);
    res_t g;
    g = got;
    if (exp.nan) g.sign = exp.sign;
    tests++;
    if (g !== exp) begin
      fails++;
      $display("FAIL %s: got s=%b e=%0d m=%h grs=%b nan=%b inf=%b, expected s=%b e=%0d m=%h grs=%b nan=%b inf=%b",
               name, got.sign, got.exp, got.mant, got.grs, got.nan, got.inf,
               exp.sign, exp.exp, exp.mant, exp.grs, exp.nan, exp.inf);
    end
  endtask

  task automatic check_val(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor: handshake values are stable from negedge to the next posedge.
  res_t held;
  logic held_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      held_v = 1'b0;
    end else begin
      if (bus.out_valid && held_v) begin
        tests++;
        if (dut_res() !== held) begin
          fails++;
          $display("FAIL hold: outputs changed under backpressure, got %h expected %h", dut_res(), held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) check_val("spurious_out", 1, 0);
        else check_res("scoreboard", dut_res(), sb_q.pop_front());
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = dut_res();
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(ref_model(bus.in_a, bus.in_b, bus.in_sub));
    end
  end

  function automatic logic [15:0] rand_fp();
    logic [15:0] v;
    int          k;
    v = 16'($urandom);
    k = int'($urandom_range(0, 7));
    if (k == 0) v[14:10] = 5'h1F;
    if (k == 1) v[14:10] = 5'h00;
    if (k == 0 && $urandom_range(0, 1) == 0) v[9:0] = '0;
    return v;
  endfunction

  vec_t        vq[$];
  logic [15:0] bp_a[4];
  int          acc, k, oc0, guard;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;

    vq.push_back('{16'h3C00, 16'h3C00, 1'b0, mk(0, 15, 'h800, 0, 0, 0)});
    vq.push_back('{16'h3C00, 16'h3C00, 1'b1, mk(0, 15, 'h000, 0, 0, 0)});
    vq.push_back('{16'h8000, 16'h8000, 1'b0, mk(1, 1,  'h000, 0, 0, 0)});
    vq.push_back('{16'h3C00, 16'h0C00, 1'b0, mk(0, 15, 'h400, 2, 0, 0)});
    vq.push_back('{16'h3C00, 16'h0001, 1'b0, mk(0, 15, 'h400, 1, 0, 0)});
    vq.push_back('{16'h0001, 16'h0001, 1'b0, mk(0, 1,  'h002, 0, 0, 0)});
    vq.push_back('{16'h4000, 16'h3C00, 1'b1, mk(0, 16, 'h200, 0, 0, 0)});
    vq.push_back('{16'h3C00, 16'h4000, 1'b1, mk(1, 16, 'h200, 0, 0, 0)});
    vq.push_back('{16'h3C00, 16'h0001, 1'b1, mk(0, 15, 'h3FF, 7, 0, 0)});
    vq.push_back('{16'h0000, 16'h0000, 1'b1, mk(0, 1,  'h000, 0, 0, 0)});
    vq.push_back('{16'h7C00, 16'hFC00, 1'b0, mk(0, 0,  0, 0, 1, 0)});
    vq.push_back('{16'h7C00, 16'hFC00, 1'b1, mk(0, 0,  0, 0, 0, 1)});
    vq.push_back('{16'h7E00, 16'h3C00, 1'b0, mk(0, 0,  0, 0, 1, 0)});
    vq.push_back('{16'hFC00, 16'h3C00, 1'b0, mk(1, 0,  0, 0, 0, 1)});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_out_valid", int'(bus.out_valid), 0);
    check_val("reset_in_ready", int'(bus.in_ready), 1);
    check_res("reset_outputs", dut_res(), mk(0, 0, 0, 0, 0, 0));

    // Directed table: one beat at a time, two-cycle latency checked.
    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      bus.in_a     = vq[i].a;
      bus.in_b     = vq[i].b;
      bus.in_sub   = vq[i].sub;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_val($sformatf("latency_early_%0d", i), int'(bus.out_valid), 0);
      @(negedge clk);
      check_val($sformatf("latency_%0d", i), int'(bus.out_valid), 1);
      check_res($sformatf("vec_%0d", i), dut_res(), vq[i].r);
      @(posedge clk); #1;
    end

    // Backpressure: only two beats fit.
    bp_a[0] = 16'h3C00; bp_a[1] = 16'h4200; bp_a[2] = 16'h0123; bp_a[3] = 16'hC500;
    bus.out_ready = 1'b0;
    acc = 0;
    k   = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = bp_a[k];
      bus.in_b     = 16'h3800;
      bus.in_sub   = 1'b0;
      @(negedge clk);
      if (bus.in_ready) begin acc++; k++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("bp_accepted", acc, 2);
    check_val("bp_in_ready_low", int'(bus.in_ready), 0);
    check_val("bp_out_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    oc0   = out_cnt - 0;
    oc0   = out_cnt;
    guard = 0;
    while (k < 4 && guard < 20) begin
      bus.in_a = bp_a[k];
      @(negedge clk);
      if (bus.in_ready) k++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("bp_out_count", out_cnt - oc0, 4);

    // Reset with two beats in flight, IN_VALID held during reset.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h4400 + 16'(i);
      bus.in_b     = 16'h3C00;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", int'(bus.out_valid), 0);
    check_val("rst_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    oc0 = out_cnt;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_no_ghost", out_cnt - oc0, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = rand_fp();
      bus.in_b      = ($urandom_range(0, 3) == 0) ? (bus.in_a ^ 16'($urandom_range(0, 15))) : rand_fp();
      bus.in_sub    = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("drain_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
